// File: rtl/serializer_pkg.sv
// Shared types for the word serializer: the two-state transmit FSM encoding.
`timescale 1ns/1ps
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Load port and serial bit port of the word serializer, bundled as one interface.
`timescale 1ns/1ps
interface word_serializer_if #(
  parameter int WIDTH = 32
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_last;
  logic             busy;

  // The serializer is the slave of the load side and sources the bit stream.
  modport slave (
    input  load_valid, load_data, bit_ready,
    output load_ready, bit_valid, bit_out, bit_last, busy
  );

  modport master (
    output load_valid, load_data, bit_ready,
    input  load_ready, bit_valid, bit_out, bit_last, busy
  );

endinterface

// File: rtl/register.sv
// Generic enabled register with synchronous active-high clear.
`timescale 1ns/1ps
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset)
      out <= '0;
    else if (en)
      out <= in;
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out transmitter: sends a loaded word LSB first, one bit per
// accepted beat, and can take the next word on the last beat to stream without gaps.
`timescale 1ns/1ps
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  word_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             shift_en;
  logic             is_last;
  logic             load_ready;
  logic             bit_valid;
  logic             load_fire;
  logic             beat;

  assign is_last = (state == SHIFT) && (cnt == LAST_IDX);

  // Handshake outputs; bit_valid is also held low during reset so an aborted
  // word cannot leak a bit in the reset cycle.
  always_comb begin
    load_ready = 1'b0;
    bit_valid  = 1'b0;
    case (state)
      IDLE:    load_ready = !reset;
      SHIFT: begin
        bit_valid  = !reset;
        load_ready = !reset && is_last && bus.bit_ready;
      end
      default: begin
        load_ready = 1'b0;
        bit_valid  = 1'b0;
      end
    endcase
  end

  assign load_fire = bus.load_valid && load_ready;
  assign beat      = bit_valid && bus.bit_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_fire) state_next = SHIFT;
      SHIFT:   if (beat && is_last && !load_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Counter saturates at the last index; only a new load brings it back to 0.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load_fire)
      cnt <= '0;
    else if (beat && !is_last)
      cnt <= cnt + CNT_W'(1);
  end

  assign shift_en = load_fire || beat;
  assign shift_d  = load_fire ? bus.load_data : {1'b0, shift_q[WIDTH-1:1]};

  register #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .in    (shift_d),
    .out   (shift_q)
  );

  assign bus.load_ready = load_ready;
  assign bus.bit_valid  = bit_valid;
  assign bus.bit_out    = shift_q[0];
  assign bus.bit_last   = is_last;
  assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer at WIDTH=4: loads queue their bits, and a
// monitor pops and compares on every accepted bit beat.
`timescale 1ns/1ps
module tb_word_serializer;

  logic clk = 1'b0;
  logic reset;

  word_serializer_if #(.WIDTH(4)) bus ();

  word_serializer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [1:0] sb[$];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic rst, input logic lv, input logic [3:0] ld, input logic br);
    reset          = rst;
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.bit_ready  = br;
  endtask

  // Each word contributes {bit, is_last} entries, LSB first.
  task automatic expectWord(input logic [3:0] w);
    for (int i = 0; i < 4; i++)
      sb.push_back({w[i], (i == 3)});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_bit: got bit %b with nothing queued, expected no beat at %0t",
                 bus.bit_out, $time);
      end else begin
        logic [1:0] exp;
        exp = sb.pop_front();
        checkOutput("bit_out", bus.bit_out, exp[1]);
        checkOutput("bit_last", bus.bit_last, exp[0]);
      end
    end
  end

  initial begin
    logic br_pat [7];
    br_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held for three cycles with a load pending
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("rst_load_ready", bus.load_ready, 1'b0);
      checkOutput("rst_bit_valid", bus.bit_valid, 1'b0);
      checkOutput("rst_bit_out", bus.bit_out, 1'b0);
      checkOutput("rst_busy", bus.busy, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    checkOutput("post_rst_load_ready", bus.load_ready, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst_busy", bus.busy, 1'b0);
    nextCycle();

    // Single word, no backpressure
    applyStimulus(1'b0, 1'b1, 4'b1011, 1'b1);
    @(negedge clk);
    checkOutput("single_load_ready", bus.load_ready, 1'b1);
    expectWord(4'b1011);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("single_bit_valid", bus.bit_valid, 1'b1);
      checkOutput("single_busy", bus.busy, 1'b1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("single_done_valid", bus.bit_valid, 1'b0);
    checkOutput("single_done_busy", bus.busy, 1'b0);
    checkOutput("single_sb_empty", sb.size() == 0, 1'b1);
    nextCycle();

    // Backpressure: stalled cycles hold the current bit
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b1);
    @(negedge clk);
    expectWord(4'b0110);
    nextCycle();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, br_pat[k]);
      @(negedge clk);
      if (k == 1 || k == 2)
        checkOutput("bp_hold_bit_out", bus.bit_out, 1'b1);
      if (k == 5)
        checkOutput("bp_hold_bit_last", bus.bit_last, 1'b1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("bp_done_valid", bus.bit_valid, 1'b0);
    checkOutput("bp_sb_empty", sb.size() == 0, 1'b1);
    nextCycle();

    // Gapless reload on the last beat of the first word
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b1);
    @(negedge clk);
    expectWord(4'hA);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, (k == 3), (k == 3) ? 4'h3 : 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("gap_busy", bus.busy, 1'b1);
      checkOutput("gap_bit_valid", bus.bit_valid, 1'b1);
      if (k == 3) begin
        checkOutput("gap_reload_ready", bus.load_ready, 1'b1);
        expectWord(4'h3);
      end
      nextCycle();
    end
    @(negedge clk);
    checkOutput("gap_done_valid", bus.bit_valid, 1'b0);
    checkOutput("gap_sb_empty", sb.size() == 0, 1'b1);
    nextCycle();

    // Reset in the middle of a word discards its remaining bits
    applyStimulus(1'b0, 1'b1, 4'hC, 1'b1);
    @(negedge clk);
    expectWord(4'hC);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
      @(negedge clk);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    sb.delete();
    @(negedge clk);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
    @(negedge clk);
    checkOutput("mid_rst_bit_valid", bus.bit_valid, 1'b0);
    checkOutput("mid_rst_load_ready", bus.load_ready, 1'b1);
    expectWord(4'h5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("mid_rst_done_valid", bus.bit_valid, 1'b0);
    checkOutput("mid_rst_sb_empty", sb.size() == 0, 1'b1);
    nextCycle();

    // A load offered before the last beat is refused and never sent
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b1);
    @(negedge clk);
    expectWord(4'h9);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, (k == 1), (k == 1) ? 4'h6 : 4'h0, 1'b1);
      @(negedge clk);
      if (k == 1)
        checkOutput("ignored_load_ready", bus.load_ready, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("ignored_done_valid", bus.bit_valid, 1'b0);
    checkOutput("ignored_done_busy", bus.busy, 1'b0);
    checkOutput("ignored_sb_empty", sb.size() == 0, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("ignored_still_idle", bus.bit_valid, 1'b0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
